// File: rtl/pmem_responder.sv
// Memory-side endpoint of the 256-bit line interface. It serves one line transaction at a
// time with a fixed latency from a small line store, and sets a sticky flag on protocol misuse.
module pmem_responder #(
  parameter int unsigned LATENCY  = 10,
  parameter int unsigned IDX_BITS = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         read,
  input  logic         write,
  input  logic [31:0]  address,
  input  logic [255:0] wdata,
  output logic [255:0] rdata,
  output logic         resp,
  output logic         err
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                state_q, state_d;
  logic [7:0]            count_q, count_d;
  logic                  wr_q, wr_d;
  logic [IDX_BITS-1:0]   idx_q, idx_d;
  logic [255:0]          wdata_q, wdata_d;
  logic [255:0]          rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  mem_we;
  logic [255:0]          mem_q [2**IDX_BITS];

  logic [IDX_BITS-1:0]   req_idx;
  logic                  unused_addr;

  assign req_idx     = address[IDX_BITS+4:5];
  assign unused_addr = ^{address[31:IDX_BITS+5], address[4:0]};

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    wr_d    = wr_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (read || write) begin
          // A simultaneous read+write is treated as a write and flagged.
          wr_d    = write;
          idx_d   = req_idx;
          wdata_d = wdata;
          count_d = 8'(LATENCY - 1);
          if (read && write) err_d = 1'b1;
          if (LATENCY == 1) begin
            state_d = RESP;
            if (!write) rdata_d = mem_q[req_idx];
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        count_d = count_q - 8'd1;
        if (!read && !write) err_d = 1'b1;
        if (count_q == 8'd1) begin
          state_d = RESP;
          if (!wr_q) rdata_d = mem_q[idx_q];
        end
      end
      RESP: begin
        state_d = IDLE;
        mem_we  = wr_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= 8'd0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Store is never cleared; a reset landing on the commit edge drops the write.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) mem_q[idx_q] <= wdata_q;
  end

  assign resp  = (state_q == RESP);
  assign rdata = rdata_q;
  assign err   = err_q;

endmodule
